// File: rtl/miriscv_ram_arb_pkg.sv
// Shared types for the miriscv RAM data-port arbiter: master identifiers and arbitration modes.
package miriscv_ram_arb_pkg;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_DMA  = 1'b1
  } mst_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/miriscv_arb_starve_cnt.sv
// Saturating count of consecutive cycles the DMA has been refused; at_limit is registered state.
// No latency beyond the counter flop; no backpressure of its own.
module miriscv_arb_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_W)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/miriscv_ram_arbiter.sv
// Two-master arbiter for the RAM data port: grant is combinational, response returns 1 cycle later.
// Refused masters hold their request (gnt is the only backpressure); one grant per cycle.
module miriscv_ram_arbiter
  import miriscv_ram_arb_pkg::*;
#(
  parameter int ARB_MODE     = ARB_FIXED,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_be_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  logic resp_valid_q, resp_valid_d;
  mst_e resp_owner_q, resp_owner_d;
  mst_e last_grant_q, last_grant_d;
  logic starve_at_limit;
  logic core_gnt, dma_gnt, dma_wins;

  miriscv_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .inc_i     (dma_req_i & ~dma_gnt),
    .clr_i     (~dma_req_i | dma_gnt),
    .at_limit_o(starve_at_limit)
  );

  // dma_wins only matters on a conflict; lone requests are always granted.
  always_comb begin
    if (ARB_MODE == ARB_RR) begin
      dma_wins = (last_grant_q == MST_CORE);
    end else begin
      dma_wins = starve_at_limit;
    end
    core_gnt = core_req_i & ~(dma_req_i & dma_wins);
    dma_gnt  = dma_req_i & ~(core_req_i & ~dma_wins);
  end

  always_comb begin
    ram_req_o   = core_gnt | dma_gnt;
    ram_we_o    = core_we_i & core_gnt;
    ram_be_o    = core_be_i;
    ram_addr_o  = core_addr_i;
    ram_wdata_o = core_wdata_i;
    if (dma_gnt) begin
      ram_we_o    = dma_we_i;
      ram_be_o    = dma_be_i;
      ram_addr_o  = dma_addr_i;
      ram_wdata_o = dma_wdata_i;
    end
  end

  always_comb begin
    resp_valid_d = core_gnt | dma_gnt;
    resp_owner_d = resp_owner_q;
    last_grant_d = last_grant_q;
    if (core_gnt | dma_gnt) begin
      resp_owner_d = dma_gnt ? MST_DMA : MST_CORE;
      last_grant_d = dma_gnt ? MST_DMA : MST_CORE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= MST_CORE;
      last_grant_q <= MST_DMA;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign core_gnt_o    = core_gnt;
  assign dma_gnt_o     = dma_gnt;
  assign core_rvalid_o = resp_valid_q & (resp_owner_q == MST_CORE);
  assign dma_rvalid_o  = resp_valid_q & (resp_owner_q == MST_DMA);
  assign core_rdata_o  = ram_rdata_i;
  assign dma_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Directed and random checks of the RAM arbiter: instance 0 is fixed priority (limit 4), instance 1 round-robin.
module tb_miriscv_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        core_req[2], core_we[2], core_gnt[2], core_rvalid[2];
  logic [3:0]  core_be[2];
  logic [31:0] core_addr[2], core_wdata[2], core_rdata[2];
  logic        dma_req[2], dma_we[2], dma_gnt[2], dma_rvalid[2];
  logic [3:0]  dma_be[2];
  logic [31:0] dma_addr[2], dma_wdata[2], dma_rdata[2];
  logic        ram_req[2], ram_we[2];
  logic [3:0]  ram_be[2];
  logic [31:0] ram_addr[2], ram_wdata[2];
  logic [31:0] rd0, rd1;

  logic [31:0] mem0 [64] = '{4: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] mem1 [64] = '{4: 32'hDEADBEEF, default: 32'h0};

  miriscv_ram_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) u_fix (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_req_i(core_req[0]), .core_we_i(core_we[0]), .core_be_i(core_be[0]),
    .core_addr_i(core_addr[0]), .core_wdata_i(core_wdata[0]), .core_gnt_o(core_gnt[0]),
    .core_rvalid_o(core_rvalid[0]), .core_rdata_o(core_rdata[0]),
    .dma_req_i(dma_req[0]), .dma_we_i(dma_we[0]), .dma_be_i(dma_be[0]),
    .dma_addr_i(dma_addr[0]), .dma_wdata_i(dma_wdata[0]), .dma_gnt_o(dma_gnt[0]),
    .dma_rvalid_o(dma_rvalid[0]), .dma_rdata_o(dma_rdata[0]),
    .ram_req_o(ram_req[0]), .ram_we_o(ram_we[0]), .ram_be_o(ram_be[0]),
    .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(rd0)
  );

  miriscv_ram_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(8)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_req_i(core_req[1]), .core_we_i(core_we[1]), .core_be_i(core_be[1]),
    .core_addr_i(core_addr[1]), .core_wdata_i(core_wdata[1]), .core_gnt_o(core_gnt[1]),
    .core_rvalid_o(core_rvalid[1]), .core_rdata_o(core_rdata[1]),
    .dma_req_i(dma_req[1]), .dma_we_i(dma_we[1]), .dma_be_i(dma_be[1]),
    .dma_addr_i(dma_addr[1]), .dma_wdata_i(dma_wdata[1]), .dma_gnt_o(dma_gnt[1]),
    .dma_rvalid_o(dma_rvalid[1]), .dma_rdata_o(dma_rdata[1]),
    .ram_req_o(ram_req[1]), .ram_we_o(ram_we[1]), .ram_be_o(ram_be[1]),
    .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(rd1)
  );

  // RAM models: registered read, byte-enabled write.
  always @(posedge clk) begin
    if (ram_req[0]) begin
      if (ram_we[0]) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[0][b]) mem0[ram_addr[0][7:2]][8*b +: 8] <= ram_wdata[0][8*b +: 8];
      end else begin
        rd0 <= mem0[ram_addr[0][7:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (ram_req[1]) begin
      if (ram_we[1]) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[1][b]) mem1[ram_addr[1][7:2]][8*b +: 8] <= ram_wdata[1][8*b +: 8];
      end else begin
        rd1 <= mem1[ram_addr[1][7:2]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int i, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    core_req[i] = req; core_we[i] = we; core_be[i] = 4'hF;
    core_addr[i] = addr; core_wdata[i] = wdata;
  endtask

  task automatic set_dma(input int i, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dma_req[i] = req; dma_we[i] = we; dma_be[i] = 4'hF;
    dma_addr[i] = addr; dma_wdata[i] = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  int   gc[2][2], rc[2][2];
  int   dbl, orphan, wait0, maxw;
  logic cg[2], dg[2];
  logic exp_dma;

  initial begin
    for (int i = 0; i < 2; i++) begin
      set_core(i, 1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(i, 1'b0, 1'b0, 32'h0, 32'h0);
      gc[i][0] = 0; gc[i][1] = 0; rc[i][0] = 0; rc[i][1] = 0;
    end
    dbl = 0; orphan = 0; wait0 = 0; maxw = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst core_rvalid", core_rvalid[0], 1'b0);
    chk("rst dma_rvalid", dma_rvalid[0], 1'b0);
    chk("rst ram_req", ram_req[0], 1'b0);
    chk("rst rr rvalid", core_rvalid[1] | dma_rvalid[1], 1'b0);
    next_cycle();
    rst_n = 1'b1;

    // 1: core-only read of 0x10
    set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t1 core_gnt", core_gnt[0], 1'b1);
    chk("t1 dma_gnt", dma_gnt[0], 1'b0);
    chk("t1 ram_addr", ram_addr[0], 32'h10);
    chk("t1 ram_we", ram_we[0], 1'b0);
    next_cycle();
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1 core_rvalid", core_rvalid[0], 1'b1);
    chk("t1 core_rdata", core_rdata[0], 32'hDEADBEEF);
    chk("t1 dma_rvalid", dma_rvalid[0], 1'b0);
    chk("t1 idle ram_we", ram_we[0], 1'b0);
    next_cycle();

    // 2: DMA write 0xA5A5A5A5 to 0x20, then core reads it back
    set_dma(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(negedge clk);
    chk("t2 dma_gnt", dma_gnt[0], 1'b1);
    chk("t2 ram_we", ram_we[0], 1'b1);
    chk("t2 ram_wdata", ram_wdata[0], 32'hA5A5A5A5);
    chk("t2 ram_addr", ram_addr[0], 32'h20);
    next_cycle();
    set_dma(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("t2 dma_rvalid", dma_rvalid[0], 1'b1);
    chk("t2 core_rvalid early", core_rvalid[0], 1'b0);
    chk("t2 core_gnt", core_gnt[0], 1'b1);
    next_cycle();
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2 core_rvalid", core_rvalid[0], 1'b1);
    chk("t2 core_rdata", core_rdata[0], 32'hA5A5A5A5);
    next_cycle();

    // 3: fixed priority, limit 4: core x4, DMA, core x4, DMA
    set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(0, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_dma = (i % 5 == 4);
      chk($sformatf("t3 dma_gnt c%0d", i), dma_gnt[0], exp_dma);
      chk($sformatf("t3 core_gnt c%0d", i), core_gnt[0], !exp_dma);
      if (exp_dma) chk($sformatf("t3 ram_addr c%0d", i), ram_addr[0], 32'h20);
      if (i > 0) begin
        exp_dma = ((i - 1) % 5 == 4);
        chk($sformatf("t3 dma_rvalid c%0d", i), dma_rvalid[0], exp_dma);
        chk($sformatf("t3 core_rvalid c%0d", i), core_rvalid[0], !exp_dma);
        chk($sformatf("t3 rdata c%0d", i), core_rdata[0], exp_dma ? 32'hA5A5A5A5 : 32'hDEADBEEF);
      end
      next_cycle();
    end
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // 4: round-robin. Lone DMA then lone core leave last_grant=CORE, so the conflict run starts with DMA.
    set_dma(1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("t4 lone dma_gnt", dma_gnt[1], 1'b1);
    chk("t4 lone core_gnt", core_gnt[1], 1'b0);
    next_cycle();
    set_dma(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t4 lone core_gnt", core_gnt[1], 1'b1);
    chk("t4 lone dma_rvalid", dma_rvalid[1], 1'b1);
    next_cycle();
    set_dma(1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_dma = (i % 2 == 0);
      chk($sformatf("t4 dma_gnt c%0d", i), dma_gnt[1], exp_dma);
      chk($sformatf("t4 core_gnt c%0d", i), core_gnt[1], !exp_dma);
      exp_dma = (i == 0) ? 1'b0 : ((i - 1) % 2 == 0);
      chk($sformatf("t4 dma_rvalid c%0d", i), dma_rvalid[1], exp_dma);
      chk($sformatf("t4 core_rvalid c%0d", i), core_rvalid[1], !exp_dma);
      next_cycle();
    end
    set_core(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // 5: reset while a response is in flight and the starve counter is at 2
    set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("t5 core_gnt a", core_gnt[0], 1'b1);
    next_cycle();
    @(negedge clk);
    chk("t5 core_gnt b", core_gnt[0], 1'b1);
    @(posedge clk);
    #2;
    chk("t5 pre-reset core_rvalid", core_rvalid[0], 1'b1);
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t5 in-reset core_rvalid", core_rvalid[0], 1'b0);
    chk("t5 in-reset dma_rvalid", dma_rvalid[0], 1'b0);
    chk("t5 in-reset rr rvalid", core_rvalid[1] | dma_rvalid[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5 post core_rvalid", core_rvalid[0], 1'b0);
    chk("t5 post dma_rvalid", dma_rvalid[0], 1'b0);
    next_cycle();
    set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(0, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t5 dma_gnt c%0d", i), dma_gnt[0], (i == 4));
      if (i == 0) chk("t5 no stale rvalid", core_rvalid[0] | dma_rvalid[0], 1'b0);
      next_cycle();
    end
    set_core(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();

    // 6: random requests on both instances, masters hold req until granted
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cg[i] = core_gnt[i];
        dg[i] = dma_gnt[i];
        if (cg[i] && dg[i]) dbl++;
        if ((cg[i] && !core_req[i]) || (dg[i] && !dma_req[i])) orphan++;
        if (cg[i]) gc[i][0]++;
        if (dg[i]) gc[i][1]++;
        if (core_rvalid[i]) rc[i][0]++;
        if (dma_rvalid[i]) rc[i][1]++;
      end
      if (dma_req[0] && !dg[0]) wait0++;
      else wait0 = 0;
      if (wait0 > maxw) maxw = wait0;
      next_cycle();
      for (int i = 0; i < 2; i++) begin
        if (!core_req[i] || cg[i])
          set_core(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        if (!dma_req[i] || dg[i])
          set_dma(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
    end
    for (int i = 0; i < 2; i++) begin
      set_core(i, 1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(i, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (core_rvalid[i]) rc[i][0]++;
      if (dma_rvalid[i]) rc[i][1]++;
    end
    chk("t6 double grant count", dbl, 0);
    chk("t6 grant without req", orphan, 0);
    chk("t6 dma wait bound", (maxw > 4), 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6 inst%0d core rvalid==gnt", i), rc[i][0], gc[i][0]);
      chk($sformatf("t6 inst%0d dma rvalid==gnt", i), rc[i][1], gc[i][1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
